sdrc_bs_convert_p: RTL and testbench

Parametrised application-to-SDRAM bus-width converter, placed between the application interface and the SDRAM transfer controller (`x2a_*` / `a2x_*`). It splits application write words into 1, 2, 4 or 8 SDRAM beats, and packs SDRAM read beats into application words through a registered packer. Against the fixed 32-bit generation it adds:
- generic `APP_DW`/`SDR_DW`;
- partial-word flush with a lane-valid mask when a burst ends mid-word;
- masking of unused SDRAM byte enables;
- a sticky configuration-error flag.

---
 rtl/sdrc_bs_pkg.sv | 48 ++++
 rtl/sdrc_bs_rd_pack.sv | 141 ++++++++++++++
 rtl/sdrc_bs_convert_p.sv | 146 ++++++++++++++
 tb/tb_sdrc_bs_convert_p.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdrc_bs_pkg.sv
// sdrc_bs_pkg: width codes and lane/ratio helpers
// shared by the SDRAM bus-width converter.
package sdrc_bs_pkg;

    localparam logic [1:0] SDR_W_FULL = 2'b00;
    localparam logic [1:0] SDR_W_HALF = 2'b01;
    localparam logic [1:0] SDR_W_QTR  = 2'b10;

    // Upper bound of lanes per application word
    localparam int MAX_R = 8;

    // Reserved code 11 behaves as quarter width
    function automatic logic [1:0] bs_norm(
        input logic [1:0] w
    );
        return (w == 2'b11) ? SDR_W_QTR : w;
    endfunction

    // Active lane width in bits
    function automatic int bs_lw(
        input logic [1:0] w,
        input int         sdr_dw
    );
        int lw;
        unique case (bs_norm(w))
            SDR_W_FULL: lw = sdr_dw;
            SDR_W_HALF: lw = sdr_dw / 2;
            default:    lw = sdr_dw / 4;
        endcase
        return lw;
    endfunction

    // Lanes per application word; each branch folds to a constant
    function automatic logic [3:0] bs_ratio(
        input logic [1:0] sdr_width,
        input int         app_dw,
        input int         sdr_dw
    );
        logic [3:0] r;
        unique case (bs_norm(sdr_width))
            SDR_W_FULL: r = 4'(app_dw / sdr_dw);
            SDR_W_HALF: r = 4'((app_dw * 2) / sdr_dw);
            default:    r = 4'((app_dw * 4) / sdr_dw);
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sdrc_bs_rd_pack.sv
// sdrc_bs_rd_pack: packs SDRAM read beats into application
// words, with partial-word flush and a lane-valid mask.
module sdrc_bs_rd_pack
    import sdrc_bs_pkg::*;
#(
    parameter int APP_DW = 64,
    parameter int SDR_DW = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        width_i,
    input  logic [3:0]        ratio_i,
    input  logic              rdstart_i,
    input  logic [SDR_DW-1:0] rddt_i,
    input  logic              rdok_i,
    input  logic              rdlast_i,
    output logic [APP_DW-1:0] data_o,
    output logic              valid_o,
    output logic [MAX_R-1:0]  lmask_o,
    output logic              last_o,
    output logic [2:0]        cnt_o
);

    localparam int SHW = $clog2(APP_DW) + 1;

    localparam logic [SDR_DW-1:0] DM_F = '1;
    localparam logic [SDR_DW-1:0] DM_H =
        SDR_DW'({(SDR_DW/2){1'b1}});
    localparam logic [SDR_DW-1:0] DM_Q =
        SDR_DW'({(SDR_DW/4){1'b1}});

    logic [APP_DW-1:0] hold_q, hold_d;
    logic [MAX_R-1:0]  mask_q, mask_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [APP_DW-1:0] data_q, data_d;
    logic              valid_q, valid_d;
    logic [MAX_R-1:0]  lmask_q, lmask_d;
    logic              last_q, last_d;

    logic [SHW-1:0]    lw;
    logic [SHW-1:0]    sh;
    logic [SDR_DW-1:0] dmask;
    logic [APP_DW-1:0] beat;
    logic [APP_DW-1:0] base_hold;
    logic [MAX_R-1:0]  base_mask;
    logic [2:0]        base_cnt;
    logic [APP_DW-1:0] merged;
    logic [MAX_R-1:0]  merged_mask;
    logic              lane_end;

    // Lane width and beat data mask for the active width
    always_comb begin
        lw    = SHW'(bs_lw(width_i, SDR_DW));
        dmask = DM_F;
        unique case (width_i)
            SDR_W_FULL: dmask = DM_F;
            SDR_W_HALF: dmask = DM_H;
            default:    dmask = DM_Q;
        endcase
    end

    // Burst start wipes partial state before this cycle's beat lands
    always_comb begin
        base_hold = rdstart_i ? '0   : hold_q;
        base_mask = rdstart_i ? '0   : mask_q;
        base_cnt  = rdstart_i ? 3'd0 : cnt_q;
    end

    // Merge the incoming beat into its lane of the holding word
    always_comb begin
        sh          = SHW'(base_cnt) * lw;
        beat        = APP_DW'(rddt_i & dmask);
        merged      = base_hold | (beat << sh);
        merged_mask = base_mask | (MAX_R'(1) << base_cnt);
        lane_end    = ({1'b0, base_cnt} == ratio_i - 4'd1);
    end

    // Next state: accumulate, emit a full word, or flush a partial one
    always_comb begin
        hold_d  = base_hold;
        mask_d  = base_mask;
        cnt_d   = base_cnt;
        data_d  = data_q;
        valid_d = 1'b0;
        lmask_d = lmask_q;
        last_d  = 1'b0;
        if (rdok_i) begin
            if (lane_end | rdlast_i) begin
                data_d  = merged;
                valid_d = 1'b1;
                lmask_d = merged_mask;
                last_d  = rdlast_i;
                hold_d  = '0;
                mask_d  = '0;
                cnt_d   = 3'd0;
            end else begin
                hold_d = merged;
                mask_d = merged_mask;
                cnt_d  = base_cnt + 3'd1;
            end
        end else if (rdlast_i) begin
            if (base_cnt != 3'd0) begin
                data_d  = base_hold;
                valid_d = 1'b1;
                lmask_d = base_mask;
                last_d  = 1'b1;
            end
            hold_d = '0;
            mask_d = '0;
            cnt_d  = 3'd0;
        end
    end

    // Holding and output registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_q  <= '0;
            mask_q  <= '0;
            cnt_q   <= 3'd0;
            data_q  <= '0;
            valid_q <= 1'b0;
            lmask_q <= '0;
            last_q  <= 1'b0;
        end else begin
            hold_q  <= hold_d;
            mask_q  <= mask_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            lmask_q <= lmask_d;
            last_q  <= last_d;
        end
    end

    assign data_o  = data_q;
    assign valid_o = valid_q;
    assign lmask_o = lmask_q;
    assign last_o  = last_q;
    assign cnt_o   = cnt_q;

endmodule

// File: rtl/sdrc_bs_convert_p.sv
// sdrc_bs_convert_p: application <-> SDRAM bus-width converter.
// Write words are split into beats; read beats are packed.
module sdrc_bs_convert_p
    import sdrc_bs_pkg::*;
#(
    parameter int APP_DW = 64,
    parameter int SDR_DW = 32,
    parameter int APP_BW = APP_DW / 8,
    parameter int SDR_BW = SDR_DW / 8
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [1:0]        sdr_width,
    input  logic              x2a_wrstart,
    input  logic              x2a_wrnext,
    input  logic              x2a_wrlast,
    output logic [SDR_DW-1:0] a2x_wrdt,
    output logic [SDR_BW-1:0] a2x_wren_n,
    input  logic [APP_DW-1:0] app_wr_data,
    input  logic [APP_BW-1:0] app_wr_en_n,
    output logic              app_wr_next,
    output logic              app_last_wr,
    input  logic              x2a_rdstart,
    input  logic [SDR_DW-1:0] x2a_rddt,
    input  logic              x2a_rdok,
    input  logic              x2a_rdlast,
    output logic [APP_DW-1:0] app_rd_data,
    output logic              app_rd_valid,
    output logic [7:0]        app_rd_lmask,
    output logic              app_last_rd,
    output logic              cfg_err
);

    localparam int SHW = $clog2(APP_DW) + 1;

    localparam logic [SDR_DW-1:0] DM_F = '1;
    localparam logic [SDR_DW-1:0] DM_H =
        SDR_DW'({(SDR_DW/2){1'b1}});
    localparam logic [SDR_DW-1:0] DM_Q =
        SDR_DW'({(SDR_DW/4){1'b1}});
    localparam logic [SDR_BW-1:0] BM_F = '1;
    localparam logic [SDR_BW-1:0] BM_H =
        SDR_BW'({(SDR_BW/2){1'b1}});
    localparam logic [SDR_BW-1:0] BM_Q =
        SDR_BW'({(SDR_BW/4){1'b1}});

    logic [1:0]        w;
    logic [3:0]        ratio;
    logic [SHW-1:0]    lw;
    logic [SHW-1:0]    wsh;
    logic [SHW-1:0]    bsh;
    logic [SDR_DW-1:0] dmask;
    logic [SDR_BW-1:0] bmask;
    logic [2:0]        wr_cnt_q, wr_cnt_d;
    logic              wr_lane_end;
    logic [2:0]        rd_cnt;
    logic [1:0]        w_q;
    logic              err_q, err_d;

    assign w     = bs_norm(sdr_width);
    assign ratio = bs_ratio(sdr_width, APP_DW, SDR_DW);
    assign lw    = SHW'(bs_lw(sdr_width, SDR_DW));

    // Data and byte-enable masks of the active lane width
    always_comb begin
        dmask = DM_F;
        bmask = BM_F;
        unique case (w)
            SDR_W_FULL: begin
                dmask = DM_F;
                bmask = BM_F;
            end
            SDR_W_HALF: begin
                dmask = DM_H;
                bmask = BM_H;
            end
            default: begin
                dmask = DM_Q;
                bmask = BM_Q;
            end
        endcase
    end

    // Select the current write lane; unused enables stay inactive
    always_comb begin
        wsh        = SHW'(wr_cnt_q) * lw;
        bsh        = wsh >> 3;
        a2x_wrdt   = SDR_DW'(app_wr_data >> wsh) & dmask;
        a2x_wren_n = SDR_BW'(app_wr_en_n >> bsh) | ~bmask;
    end

    assign wr_lane_end = ({1'b0, wr_cnt_q} == ratio - 4'd1);
    assign app_wr_next = x2a_wrnext & (wr_lane_end | x2a_wrlast);
    assign app_last_wr = x2a_wrlast;

    // Write lane counter: burst edges restart, consumed beats advance
    always_comb begin
        wr_cnt_d = wr_cnt_q;
        if (x2a_wrstart | x2a_wrlast) begin
            wr_cnt_d = 3'd0;
        end else if (x2a_wrnext) begin
            wr_cnt_d = wr_lane_end ? 3'd0 : wr_cnt_q + 3'd1;
        end
    end

    // Width change with a word half-assembled corrupts that word
    always_comb begin
        err_d = err_q |
            ((w != w_q) & ((wr_cnt_q != 3'd0) | (rd_cnt != 3'd0)));
    end

    // Write counter, sampled width and sticky error flag
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_cnt_q <= 3'd0;
            w_q      <= SDR_W_FULL;
            err_q    <= 1'b0;
        end else begin
            wr_cnt_q <= wr_cnt_d;
            w_q      <= w;
            err_q    <= err_d;
        end
    end

    assign cfg_err = err_q;

    sdrc_bs_rd_pack #(
        .APP_DW (APP_DW),
        .SDR_DW (SDR_DW)
    ) u_rd_pack (
        .clk       (clk),
        .reset_n   (reset_n),
        .width_i   (w),
        .ratio_i   (ratio),
        .rdstart_i (x2a_rdstart),
        .rddt_i    (x2a_rddt),
        .rdok_i    (x2a_rdok),
        .rdlast_i  (x2a_rdlast),
        .data_o    (app_rd_data),
        .valid_o   (app_rd_valid),
        .lmask_o   (app_rd_lmask),
        .last_o    (app_last_rd),
        .cnt_o     (rd_cnt)
    );

endmodule

// File: tb/tb_sdrc_bs_convert_p.sv
// tb_sdrc_bs_convert_p: directed and randomized checks of the
// bus-width converter against an arithmetic reference model.
module tb_sdrc_bs_convert_p;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  sdr_width;
    logic        x2a_wrstart, x2a_wrnext, x2a_wrlast;
    logic [31:0] a2x_wrdt;
    logic [3:0]  a2x_wren_n;
    logic [63:0] app_wr_data;
    logic [7:0]  app_wr_en_n;
    logic        app_wr_next, app_last_wr;
    logic        x2a_rdstart;
    logic [31:0] x2a_rddt;
    logic        x2a_rdok, x2a_rdlast;
    logic [63:0] app_rd_data;
    logic        app_rd_valid;
    logic [7:0]  app_rd_lmask;
    logic        app_last_rd;
    logic        cfg_err;

    always #5 clk = ~clk;

    sdrc_bs_convert_p #(
        .APP_DW (64),
        .SDR_DW (32)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sdr_width    (sdr_width),
        .x2a_wrstart  (x2a_wrstart),
        .x2a_wrnext   (x2a_wrnext),
        .x2a_wrlast   (x2a_wrlast),
        .a2x_wrdt     (a2x_wrdt),
        .a2x_wren_n   (a2x_wren_n),
        .app_wr_data  (app_wr_data),
        .app_wr_en_n  (app_wr_en_n),
        .app_wr_next  (app_wr_next),
        .app_last_wr  (app_last_wr),
        .x2a_rdstart  (x2a_rdstart),
        .x2a_rddt     (x2a_rddt),
        .x2a_rdok     (x2a_rdok),
        .x2a_rdlast   (x2a_rdlast),
        .app_rd_data  (app_rd_data),
        .app_rd_valid (app_rd_valid),
        .app_rd_lmask (app_rd_lmask),
        .app_last_rd  (app_last_rd),
        .cfg_err      (cfg_err)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag,
                         input logic [63:0] obs,
                         input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int lw_of(input logic [1:0] w);
        return (w == 2'd0) ? 32 : (w == 2'd1) ? 16 : 8;
    endfunction

    function automatic logic [31:0] exp_beat(input logic [63:0] d,
                                             input int lw,
                                             input int lane);
        logic [63:0] t;
        t = (d >> (lane * lw)) & ((64'd1 << lw) - 64'd1);
        return t[31:0];
    endfunction

    function automatic logic [3:0] exp_en(input logic [7:0] en,
                                          input int lw,
                                          input int lane);
        logic [3:0] r;
        logic [7:0] e;
        r = 4'hF;
        e = en >> (lane * lw / 8);
        for (int i = 0; i < lw / 8; i++) r[i] = e[i];
        return r;
    endfunction

    // One write cycle, checked against the lane/byte arithmetic
    task automatic wr_cycle(input string tag, input int lane,
                            input bit nxt, input bit last);
        int lw;
        int r;
        lw = lw_of(sdr_width);
        r  = 64 / lw;
        x2a_wrnext = nxt;
        x2a_wrlast = last;
        #1;
        check({tag, ".dt"}, a2x_wrdt, exp_beat(app_wr_data, lw, lane));
        check({tag, ".en"}, a2x_wren_n, exp_en(app_wr_en_n, lw, lane));
        check({tag, ".nx"}, app_wr_next, nxt && ((lane == r - 1) || last));
        tick();
        x2a_wrnext = 1'b0;
        x2a_wrlast = 1'b0;
    endtask

    task automatic rd_beat(input logic [31:0] d, input bit last);
        x2a_rdok   = 1'b1;
        x2a_rddt   = d;
        x2a_rdlast = last;
        tick();
        x2a_rdok   = 1'b0;
        x2a_rdlast = 1'b0;
        x2a_rddt   = $urandom();
    endtask

    task automatic rd_check(input string tag, input bit ev,
                            input logic [63:0] ed, input logic [7:0] em,
                            input bit el);
        check({tag, ".v"}, app_rd_valid, ev);
        if (ev) begin
            check({tag, ".d"}, app_rd_data, ed);
            check({tag, ".m"}, app_rd_lmask, em);
            check({tag, ".l"}, app_last_rd, el);
        end
    endtask

    initial begin
        logic [63:0] acc;
        int          n;
        int          lw;
        int          r;
        int          len;
        int          beat;
        int          lane;
        bit          last;
        bit          solo;
        logic [31:0] d;

        reset_n     = 1'b1;
        sdr_width   = 2'd0;
        x2a_wrstart = 1'b0;
        x2a_wrnext  = 1'b0;
        x2a_wrlast  = 1'b0;
        x2a_rdstart = 1'b0;
        x2a_rddt    = '0;
        x2a_rdok    = 1'b0;
        x2a_rdlast  = 1'b0;
        app_wr_data = 64'hDEAD_BEEF_CAFE_F00D;
        app_wr_en_n = 8'hA5;
        #1 reset_n = 1'b0;
        #21;

        // Reset state
        check("rst.rd_data", app_rd_data, 64'd0);
        check("rst.rd_valid", app_rd_valid, 1'b0);
        check("rst.lmask", app_rd_lmask, 8'd0);
        check("rst.last_rd", app_last_rd, 1'b0);
        check("rst.cfg_err", cfg_err, 1'b0);
        check("rst.wr_next", app_wr_next, 1'b0);
        check("rst.wrdt", a2x_wrdt, 32'hCAFE_F00D);
        check("rst.wren", a2x_wren_n, 4'h5);
        #1 reset_n = 1'b1;
        tick();

        // Full width: two beats per word
        app_wr_data = 64'h1111_2222_3333_4444;
        app_wr_en_n = 8'h0F;
        x2a_wrstart = 1'b1;
        tick();
        x2a_wrstart = 1'b0;
        x2a_wrnext  = 1'b1;
        #1;
        check("w32.b1.dt", a2x_wrdt, 32'h3333_4444);
        check("w32.b1.en", a2x_wren_n, 4'hF);
        check("w32.b1.nx", app_wr_next, 1'b0);
        tick();
        #1;
        check("w32.b2.dt", a2x_wrdt, 32'h1111_2222);
        check("w32.b2.en", a2x_wren_n, 4'h0);
        check("w32.b2.nx", app_wr_next, 1'b1);
        tick();
        x2a_wrnext = 1'b0;

        // 8-bit width: burst ends mid-word on beat 3
        sdr_width   = 2'd2;
        app_wr_data = 64'h0123_4567_89AB_CDEF;
        app_wr_en_n = 8'hFA;
        x2a_wrstart = 1'b1;
        tick();
        x2a_wrstart = 1'b0;
        for (int k = 0; k < 3; k++) begin
            x2a_wrnext = 1'b1;
            x2a_wrlast = (k == 2);
            #1;
            check("w8.dt", a2x_wrdt, exp_beat(app_wr_data, 8, k));
            check("w8.hi_en", a2x_wren_n[3:1], 3'b111);
            check("w8.nx", app_wr_next, k == 2);
            check("w8.lastwr", app_last_wr, k == 2);
            tick();
        end
        x2a_wrnext = 1'b0;
        x2a_wrlast = 1'b0;

        // 8-bit read: eight beats fill one word
        x2a_rdstart = 1'b1;
        tick();
        x2a_rdstart = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            rd_beat({24'($urandom()), 8'(i)}, i == 8);
            if (i < 8) check("r8.early", app_rd_valid, 1'b0);
        end
        rd_check("r8", 1'b1, 64'h0807_0605_0403_0201, 8'hFF, 1'b1);
        tick();
        check("r8.pulse", app_rd_valid, 1'b0);

        // 16-bit read: burst ends after three lanes
        sdr_width   = 2'd1;
        x2a_rdstart = 1'b1;
        tick();
        x2a_rdstart = 1'b0;
        rd_beat({16'($urandom()), 16'hAAAA}, 1'b0);
        rd_beat({16'($urandom()), 16'hBBBB}, 1'b0);
        rd_beat({16'($urandom()), 16'hCCCC}, 1'b1);
        rd_check("r16", 1'b1, 64'h0000_CCCC_BBBB_AAAA, 8'h07, 1'b1);

        // Stand-alone rdlast flushes held lanes
        sdr_width   = 2'd2;
        x2a_rdstart = 1'b1;
        tick();
        x2a_rdstart = 1'b0;
        rd_beat(32'h0000_0011, 1'b0);
        rd_beat(32'h0000_0022, 1'b0);
        x2a_rdlast = 1'b1;
        tick();
        x2a_rdlast = 1'b0;
        rd_check("flush", 1'b1, 64'h2211, 8'h03, 1'b1);
        x2a_rdlast = 1'b1;
        tick();
        x2a_rdlast = 1'b0;
        check("flush.empty", app_rd_valid, 1'b0);

        // Width change with two lanes held sets the sticky error
        x2a_rdstart = 1'b1;
        tick();
        x2a_rdstart = 1'b0;
        rd_beat(32'h0000_00EE, 1'b0);
        rd_beat(32'h0000_00EE, 1'b0);
        check("err.before", cfg_err, 1'b0);
        sdr_width = 2'd0;
        tick();
        check("err.set", cfg_err, 1'b1);
        x2a_rdlast = 1'b1;
        tick();
        x2a_rdlast = 1'b0;
        tick();
        tick();
        check("err.sticky", cfg_err, 1'b1);
        #2 reset_n = 1'b0;
        #1;
        check("err.rst", cfg_err, 1'b0);
        check("err.rst.v", app_rd_valid, 1'b0);
        #2 reset_n = 1'b1;
        tick();

        // Reset mid-read leaves no stale lanes behind
        sdr_width = 2'd2;
        tick();
        rd_beat(32'h0000_00EE, 1'b0);
        rd_beat(32'h0000_00EE, 1'b0);
        rd_beat(32'h0000_00EE, 1'b0);
        #2 reset_n = 1'b0;
        #1;
        check("mrst.v", app_rd_valid, 1'b0);
        check("mrst.d", app_rd_data, 64'd0);
        #2 reset_n = 1'b1;
        tick();
        x2a_rdlast = 1'b1;
        tick();
        x2a_rdlast = 1'b0;
        check("mrst.noflush", app_rd_valid, 1'b0);
        rd_beat(32'h0000_0055, 1'b0);
        rd_beat(32'h0000_0066, 1'b1);
        rd_check("mrst.next", 1'b1, 64'h6655, 8'h03, 1'b1);
        check("mrst.err", cfg_err, 1'b0);

        // Randomized write bursts
        for (int b = 0; b < 30; b++) begin
            sdr_width   = 2'($urandom_range(0, 3));
            lw          = lw_of(sdr_width);
            r           = 64 / lw;
            len         = $urandom_range(1, 2 * r);
            x2a_wrstart = 1'b1;
            tick();
            x2a_wrstart = 1'b0;
            app_wr_data = {$urandom(), $urandom()};
            app_wr_en_n = 8'($urandom());
            beat = 0;
            while (beat < len) begin
                lane = beat % r;
                if ($urandom_range(0, 3) == 0) begin
                    wr_cycle("wrnd.gap", lane, 1'b0, 1'b0);
                end else begin
                    last = (beat == len - 1);
                    wr_cycle("wrnd", lane, 1'b1, last);
                    beat++;
                    if (lane == r - 1) begin
                        app_wr_data = {$urandom(), $urandom()};
                        app_wr_en_n = 8'($urandom());
                    end
                end
            end
        end

        // Randomized read bursts against a word-assembly model
        for (int b = 0; b < 30; b++) begin
            sdr_width   = 2'($urandom_range(0, 3));
            lw          = lw_of(sdr_width);
            r           = 64 / lw;
            len         = $urandom_range(1, 2 * r + 1);
            solo        = 1'($urandom_range(0, 1));
            x2a_rdstart = 1'b1;
            tick();
            x2a_rdstart = 1'b0;
            check("rrnd.start", app_rd_valid, 1'b0);
            acc = '0;
            n   = 0;
            for (int k = 0; k < len; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    tick();
                    check("rrnd.gap", app_rd_valid, 1'b0);
                end
                d    = $urandom();
                last = (k == len - 1) && !solo;
                rd_beat(d, last);
                acc = acc | ((64'(d) & ((64'd1 << lw) - 64'd1)) << (n * lw));
                n++;
                if (n == r || last) begin
                    rd_check("rrnd", 1'b1, acc, 8'((1 << n) - 1), last);
                    acc = '0;
                    n   = 0;
                end else begin
                    check("rrnd.mid", app_rd_valid, 1'b0);
                end
            end
            if (solo) begin
                x2a_rdlast = 1'b1;
                tick();
                x2a_rdlast = 1'b0;
                rd_check("rrnd.flush", n != 0, acc,
                         8'((1 << n) - 1), 1'b1);
            end
        end
        check("final.err", cfg_err, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
